// File: rtl/sargantana_icache_pkg.sv
// Shared definitions for the icache-to-L1.5 request arbiter: request size
// codes, the instruction-fill return type, arbiter states and the request bundle.
package sargantana_icache_pkg;

  localparam int L15_ADDR_W = 40;

  localparam logic [2:0] L15_SIZE_NC   = 3'b011;
  localparam logic [2:0] L15_SIZE_LINE = 3'b111;

  localparam logic [3:0] RTN_IFILL_DEF = 4'h1;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_REQ  = 2'd1;
  localparam arb_state_t ST_WAIT = 2'd2;

  typedef struct packed {
    logic                  nc;
    logic [2:0]            size;
    logic [L15_ADDR_W-1:0] addr;
  } l15_req_t;

endpackage

// File: rtl/icache_l15_line_assembler.sv
// Collects 64-bit instruction-fill beats into a cache line and raises a
// one-cycle done pulse the cycle after the final beat is written.
module icache_l15_line_assembler #(
  parameter int LINE_BEATS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     beat_valid_i,
  input  logic [63:0]              beat_data_i,
  output logic                     last_beat_o,
  output logic                     done_o,
  output logic [64*LINE_BEATS-1:0] line_o
);

  localparam int CNT_W = $clog2(LINE_BEATS);

  logic [CNT_W-1:0]          cnt_q;
  logic [64*LINE_BEATS-1:0]  line_q;
  logic                      done_q;

  assign last_beat_o = beat_valid_i & (cnt_q == CNT_W'(LINE_BEATS - 1));
  assign done_o      = done_q;
  assign line_o      = line_q;

  // Write each beat into its slot; the counter wraps naturally at a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_beat_o;
      if (beat_valid_i) begin
        line_q[cnt_q*64 +: 64] <= beat_data_i;
        cnt_q                  <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_l15_req_arb.sv
// Arbitrates non-cacheable fetches (strict priority) and icache line fills
// onto a single L1.5 request channel with one transaction in flight.
module icache_l15_req_arb
  import sargantana_icache_pkg::*;
#(
  parameter int         PADDR_W    = 40,
  parameter int         LINE_BEATS = 4,
  parameter logic [3:0] RTN_IFILL  = RTN_IFILL_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     nc_req_valid_i,
  input  logic [PADDR_W-1:0]       nc_req_addr_i,
  output logic                     nc_grant_valid_o,
  output logic [63:0]              nc_resp_data_o,
  input  logic                     fill_req_valid_i,
  input  logic [PADDR_W-1:0]       fill_req_addr_i,
  output logic                     fill_req_ready_o,
  output logic                     fill_resp_valid_o,
  output logic [64*LINE_BEATS-1:0] fill_resp_line_o,
  output logic                     l15_req_val_o,
  output logic                     l15_req_nc_o,
  output logic [2:0]               l15_req_size_o,
  output logic [PADDR_W-1:0]       l15_req_addr_o,
  input  logic                     l15_req_ack_i,
  input  logic                     l15_resp_val_i,
  input  logic [3:0]               l15_resp_type_i,
  input  logic [63:0]              l15_resp_data_i,
  output logic                     l15_resp_ack_o
);

  localparam logic [PADDR_W-1:0] LINE_MASK = PADDR_W'((8 * LINE_BEATS) - 1);
  localparam logic [PADDR_W-1:0] WORD_MASK = PADDR_W'(7);

  arb_state_t          state_q;
  logic                nc_pend_q;
  logic [PADDR_W-1:0]  nc_addr_q;
  l15_req_t            req_q;

  logic                fill_hs;
  logic                ifill_beat;
  logic                line_beat;
  logic                last_beat;
  logic [PADDR_W-1:0]  nc_src_addr;
  logic [PADDR_W-1:0]  nc_aligned;
  logic [PADDR_W-1:0]  fill_aligned;

  // A fresh pulse is always the newest request, so it bypasses the stored address
  assign nc_src_addr  = nc_req_valid_i ? nc_req_addr_i : nc_addr_q;
  assign nc_aligned   = nc_src_addr & ~WORD_MASK;
  assign fill_aligned = fill_req_addr_i & ~LINE_MASK;

  assign fill_req_ready_o = ~rst_i & (state_q == ST_IDLE) & ~nc_pend_q & ~nc_req_valid_i;
  assign fill_hs          = fill_req_valid_i & fill_req_ready_o;

  assign l15_req_val_o  = (state_q == ST_REQ);
  assign l15_req_nc_o   = l15_req_val_o & req_q.nc;
  assign l15_req_size_o = l15_req_val_o ? req_q.size : 3'b000;
  assign l15_req_addr_o = l15_req_val_o ? PADDR_W'(req_q.addr) : '0;

  // Every beat is consumed; only IFILL beats in WAIT carry useful data
  assign l15_resp_ack_o = ~rst_i & l15_resp_val_i;
  assign ifill_beat     = (state_q == ST_WAIT) & l15_resp_val_i & (l15_resp_type_i == RTN_IFILL);

  assign nc_grant_valid_o = ifill_beat & req_q.nc;
  assign nc_resp_data_o   = nc_grant_valid_o ? l15_resp_data_i : 64'd0;
  assign line_beat        = ifill_beat & ~req_q.nc;

  // Pending non-cacheable request: set on any pulse, cleared when its header is accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nc_pend_q <= 1'b0;
      nc_addr_q <= '0;
    end else if (nc_req_valid_i) begin
      nc_pend_q <= 1'b1;
      nc_addr_q <= nc_req_addr_i;
    end else if ((state_q == ST_REQ) && l15_req_ack_i && req_q.nc) begin
      nc_pend_q <= 1'b0;
    end
  end

  // Transaction sequencer: pick a source, hold the header until acked, await the data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (nc_req_valid_i || nc_pend_q) begin
            req_q   <= '{nc: 1'b1, size: L15_SIZE_NC, addr: L15_ADDR_W'(nc_aligned)};
            state_q <= ST_REQ;
          end else if (fill_hs) begin
            req_q   <= '{nc: 1'b0, size: L15_SIZE_LINE, addr: L15_ADDR_W'(fill_aligned)};
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (l15_req_ack_i) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (nc_grant_valid_o || last_beat) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  icache_l15_line_assembler #(
    .LINE_BEATS (LINE_BEATS)
  ) u_line_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .beat_valid_i (line_beat),
    .beat_data_i  (l15_resp_data_i),
    .last_beat_o  (last_beat),
    .done_o       (fill_resp_valid_o),
    .line_o       (fill_resp_line_o)
  );

endmodule

// File: tb/tb_icache_l15_req_arb.sv
// Directed scoreboard bench for the icache L1.5 request arbiter.
module tb_icache_l15_req_arb;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         nc_req_valid_i;
  logic [39:0]  nc_req_addr_i;
  logic         nc_grant_valid_o;
  logic [63:0]  nc_resp_data_o;
  logic         fill_req_valid_i;
  logic [39:0]  fill_req_addr_i;
  logic         fill_req_ready_o;
  logic         fill_resp_valid_o;
  logic [255:0] fill_resp_line_o;
  logic         l15_req_val_o;
  logic         l15_req_nc_o;
  logic [2:0]   l15_req_size_o;
  logic [39:0]  l15_req_addr_o;
  logic         l15_req_ack_i;
  logic         l15_resp_val_i;
  logic [3:0]   l15_resp_type_i;
  logic [63:0]  l15_resp_data_i;
  logic         l15_resp_ack_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        tag;
    logic [319:0] val;
  } sb_t;
  sb_t sb_q[$];

  icache_l15_req_arb #(
    .PADDR_W    (40),
    .LINE_BEATS (4),
    .RTN_IFILL  (4'h1)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .nc_req_valid_i    (nc_req_valid_i),
    .nc_req_addr_i     (nc_req_addr_i),
    .nc_grant_valid_o  (nc_grant_valid_o),
    .nc_resp_data_o    (nc_resp_data_o),
    .fill_req_valid_i  (fill_req_valid_i),
    .fill_req_addr_i   (fill_req_addr_i),
    .fill_req_ready_o  (fill_req_ready_o),
    .fill_resp_valid_o (fill_resp_valid_o),
    .fill_resp_line_o  (fill_resp_line_o),
    .l15_req_val_o     (l15_req_val_o),
    .l15_req_nc_o      (l15_req_nc_o),
    .l15_req_size_o    (l15_req_size_o),
    .l15_req_addr_o    (l15_req_addr_o),
    .l15_req_ack_i     (l15_req_ack_i),
    .l15_resp_val_i    (l15_resp_val_i),
    .l15_resp_type_i   (l15_resp_type_i),
    .l15_resp_data_i   (l15_resp_data_i),
    .l15_resp_ack_o    (l15_resp_ack_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [319:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [319:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL sb_underflow: observed %0h with nothing expected", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [319:0] req_pack(input logic v, input logic nc,
                                            input logic [2:0] sz, input logic [39:0] a);
    return 320'({v, nc, sz, a});
  endfunction

  function automatic logic [319:0] line4(input logic [63:0] b3, input logic [63:0] b2,
                                         input logic [63:0] b1, input logic [63:0] b0);
    return 320'({1'b1, b3, b2, b1, b0});
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  // Offer a fill request and wait (bounded) for the handshake
  task automatic start_fill(input logic [39:0] a);
    int waited;
    waited = 0;
    fill_req_valid_i = 1'b1;
    fill_req_addr_i  = a;
    sample();
    while (!fill_req_ready_o && waited < 20) begin
      step();
      sample();
      waited++;
    end
    check("fill_handshake", 320'(fill_req_ready_o), 320'(1));
    step();
    fill_req_valid_i = 1'b0;
    fill_req_addr_i  = 40'hFF_FFFF_FFFF;
  endtask

  // Check the held header for 'hold' cycles, then ack it
  task automatic expect_req_and_ack(input string tag, input logic nc, input logic [2:0] sz,
                                    input logic [39:0] a, input int hold);
    for (int i = 0; i < hold; i++) begin
      sb_push(tag, req_pack(1'b1, nc, sz, a));
      sample();
      sb_check(req_pack(l15_req_val_o, l15_req_nc_o, l15_req_size_o, l15_req_addr_o));
      step();
    end
    l15_req_ack_i = 1'b1;
    sb_push(tag, req_pack(1'b1, nc, sz, a));
    sample();
    sb_check(req_pack(l15_req_val_o, l15_req_nc_o, l15_req_size_o, l15_req_addr_o));
    step();
    l15_req_ack_i = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] t, input logic [63:0] d,
                           input logic nc_pulse, input logic [39:0] nc_addr);
    l15_resp_val_i  = 1'b1;
    l15_resp_type_i = t;
    l15_resp_data_i = d;
    nc_req_valid_i  = nc_pulse;
    nc_req_addr_i   = nc_addr;
    sample();
    check("beat_ack", 320'(l15_resp_ack_o), 320'(1));
    check("no_early_done", 320'(fill_resp_valid_o), 320'(0));
    step();
    l15_resp_val_i  = 1'b0;
    l15_resp_type_i = 4'h0;
    l15_resp_data_i = 64'd0;
    nc_req_valid_i  = 1'b0;
  endtask

  task automatic nc_beat(input string tag, input logic [63:0] d);
    sb_push(tag, 320'({1'b1, d}));
    l15_resp_val_i  = 1'b1;
    l15_resp_type_i = 4'h1;
    l15_resp_data_i = d;
    sample();
    sb_check(320'({nc_grant_valid_o, nc_resp_data_o}));
    step();
    l15_resp_val_i  = 1'b0;
    l15_resp_type_i = 4'h0;
    l15_resp_data_i = 64'd0;
  endtask

  task automatic check_line(input string tag);
    sample();
    sb_check(320'({fill_resp_valid_o, fill_resp_line_o}));
    step();
    sample();
    check({tag, "_width"}, 320'(fill_resp_valid_o), 320'(0));
    step();
  endtask

  function automatic logic [319:0] all_outs();
    return 320'({l15_req_val_o, l15_req_nc_o, l15_req_size_o, l15_req_addr_o,
                 nc_grant_valid_o, nc_resp_data_o, fill_req_ready_o,
                 fill_resp_valid_o, l15_resp_ack_o});
  endfunction

  initial begin
    rst_i            = 1'b1;
    nc_req_valid_i   = 1'b0;
    nc_req_addr_i    = 40'd0;
    fill_req_valid_i = 1'b0;
    fill_req_addr_i  = 40'd0;
    l15_req_ack_i    = 1'b0;
    l15_resp_val_i   = 1'b1;
    l15_resp_type_i  = 4'h1;
    l15_resp_data_i  = 64'h1234;

    // Reset state, with a beat presented that must not be acked
    step();
    sample();
    check("rst_outputs", all_outs(), 320'(0));
    check("rst_line", 320'(fill_resp_line_o), 320'(0));
    step();
    rst_i           = 1'b0;
    l15_resp_val_i  = 1'b0;
    l15_resp_type_i = 4'h0;
    l15_resp_data_i = 64'd0;
    step();

    // 1: non-cacheable fetch with a dropped foreign beat before the data
    $display("[TB] test 1: nc fetch");
    nc_req_valid_i = 1'b1;
    nc_req_addr_i  = 40'h00_0001_0004;
    sample();
    check("t1_ready_blocked", 320'(fill_req_ready_o), 320'(0));
    step();
    nc_req_valid_i = 1'b0;
    expect_req_and_ack("t1_req", 1'b1, 3'b011, 40'h00_0001_0000, 0);
    l15_resp_val_i  = 1'b1;
    l15_resp_type_i = 4'h3;
    l15_resp_data_i = 64'hFFFF_0000_FFFF_0000;
    sample();
    check("t1_foreign_ack", 320'(l15_resp_ack_o), 320'(1));
    check("t1_foreign_no_grant", 320'(nc_grant_valid_o), 320'(0));
    step();
    nc_beat("t1_grant", 64'hDEAD_BEEF_0123_4567);
    sample();
    check("t1_after_grant", 320'({nc_grant_valid_o, fill_req_ready_o}), 320'({1'b0, 1'b1}));
    step();

    // 2: plain line fill
    $display("[TB] test 2: line fill");
    start_fill(40'h80_0000_0028);
    expect_req_and_ack("t2_req", 1'b0, 3'b111, 40'h80_0000_0020, 0);
    sb_push("t2_line", line4(64'd4, 64'd3, 64'd2, 64'd1));
    for (int i = 1; i <= 4; i++) send_beat(4'h1, 64'(i), 1'b0, 40'd0);
    check_line("t2_line");

    // 3: nc pulses during a fill wait; latest address wins after the fill
    $display("[TB] test 3: nc during fill");
    start_fill(40'h00_0000_1040);
    expect_req_and_ack("t3_req", 1'b0, 3'b111, 40'h00_0000_1040, 0);
    sb_push("t3_line", line4(64'h34, 64'h33, 64'h32, 64'h31));
    send_beat(4'h1, 64'h31, 1'b1, 40'h00_0000_1008);
    send_beat(4'h1, 64'h32, 1'b0, 40'd0);
    send_beat(4'h1, 64'h33, 1'b1, 40'h00_0000_2008);
    send_beat(4'h1, 64'h34, 1'b0, 40'd0);
    sample();
    sb_check(320'({fill_resp_valid_o, fill_resp_line_o}));
    check("t3_ready_held", 320'(fill_req_ready_o), 320'(0));
    check("t3_idle_gap", 320'(l15_req_val_o), 320'(0));
    fill_req_valid_i = 1'b1;
    fill_req_addr_i  = 40'h00_0000_7000;
    step();
    expect_req_and_ack("t3_nc_req", 1'b1, 3'b011, 40'h00_0000_2008, 0);
    nc_beat("t3_nc_grant", 64'hCAFE_F00D_0000_2008);
    fill_req_valid_i = 1'b0;
    sample();
    check("t3_ready_back", 320'(fill_req_ready_o), 320'(1));
    step();

    // 4: foreign-type beat inside a fill is dropped
    $display("[TB] test 4: foreign beat in fill");
    start_fill(40'h00_0000_3000);
    expect_req_and_ack("t4_req", 1'b0, 3'b111, 40'h00_0000_3000, 0);
    sb_push("t4_line", line4(64'h44, 64'h33, 64'h22, 64'h11));
    send_beat(4'h1, 64'h11, 1'b0, 40'd0);
    send_beat(4'h3, 64'hBAD, 1'b0, 40'd0);
    send_beat(4'h1, 64'h22, 1'b0, 40'd0);
    send_beat(4'h1, 64'h33, 1'b0, 40'd0);
    send_beat(4'h1, 64'h44, 1'b0, 40'd0);
    check_line("t4_line");

    // 5: reset after two beats, then a clean fill
    $display("[TB] test 5: reset mid-fill");
    start_fill(40'h00_0000_4000);
    expect_req_and_ack("t5_req", 1'b0, 3'b111, 40'h00_0000_4000, 0);
    send_beat(4'h1, 64'hAA, 1'b0, 40'd0);
    send_beat(4'h1, 64'hBB, 1'b0, 40'd0);
    rst_i           = 1'b1;
    l15_resp_val_i  = 1'b1;
    l15_resp_type_i = 4'h1;
    l15_resp_data_i = 64'hCC;
    sample();
    check("t5_rst_outputs", all_outs(), 320'(0));
    check("t5_rst_line", 320'(fill_resp_line_o), 320'(0));
    step();
    rst_i           = 1'b0;
    l15_resp_val_i  = 1'b0;
    l15_resp_type_i = 4'h0;
    l15_resp_data_i = 64'd0;
    step();
    start_fill(40'h00_0000_5000);
    expect_req_and_ack("t5_req2", 1'b0, 3'b111, 40'h00_0000_5000, 0);
    sb_push("t5_line", line4(64'd8, 64'd7, 64'd6, 64'd5));
    for (int i = 5; i <= 8; i++) send_beat(4'h1, 64'(i), 1'b0, 40'd0);
    check_line("t5_line");

    // 6: header held for five cycles while a stray beat arrives outside WAIT
    $display("[TB] test 6: withheld ack");
    start_fill(40'h00_0000_6010);
    for (int i = 0; i < 5; i++) begin
      sb_push("t6_hold", req_pack(1'b1, 1'b0, 3'b111, 40'h00_0000_6000));
      if (i == 2) begin
        l15_resp_val_i  = 1'b1;
        l15_resp_type_i = 4'h1;
        l15_resp_data_i = 64'h999;
      end
      sample();
      sb_check(req_pack(l15_req_val_o, l15_req_nc_o, l15_req_size_o, l15_req_addr_o));
      if (i == 2) check("t6_stray_ack", 320'(l15_resp_ack_o), 320'(1));
      step();
      l15_resp_val_i  = 1'b0;
      l15_resp_type_i = 4'h0;
      l15_resp_data_i = 64'd0;
    end
    expect_req_and_ack("t6_req", 1'b0, 3'b111, 40'h00_0000_6000, 0);
    sb_push("t6_line", line4(64'h64, 64'h63, 64'h62, 64'h61));
    for (int i = 1; i <= 4; i++) send_beat(4'h1, 64'(8'h60 + i), 1'b0, 40'd0);
    check_line("t6_line");

    check("sb_empty", 320'(sb_q.size()), 320'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_l15_req_arb.md
Name: icache_l15_req_arb

Overview:
- Sits directly downstream of the non-cacheable fetch buffer and the L1 instruction cache, between them and the OpenPiton L1.5 (NoC) interface.
- Arbitrates cacheable line-fill requests and non-cacheable 8-byte fetch requests onto a single L1.5 request channel, with one transaction outstanding at a time.
- Collects 64-bit response beats and returns either a full line to the icache or a single 64-bit word plus grant pulse to the non-cacheable buffer.

Parameters:
- PADDR_W, 40, physical address width.
- LINE_BEATS, 4, 64-bit beats per cacheable line (line = 64*LINE_BEATS bits); power of two, ≥2.
- RTN_IFILL, 4'h1, L1.5 returntype code for an instruction fill.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- nc_req_valid_i  in  1  one-cycle pulse: non-cacheable fetch request (no ready; must never be lost).
- nc_req_addr_i  in  PADDR_W  8B-aligned nc address, valid with pulse.
- nc_grant_valid_o  out  1  one-cycle pulse: nc data returned.
- nc_resp_data_o  out  64  nc data, valid only while nc_grant_valid_o=1.
- fill_req_valid_i  in  1  icache miss request.
- fill_req_addr_i  in  PADDR_W  miss address (any alignment).
- fill_req_ready_o  out  1  fill request accepted this cycle.
- fill_resp_valid_o  out  1  one-cycle pulse: full line returned.
- fill_resp_line_o  out  64*LINE_BEATS  assembled line, beat 0 in LSBs.
- l15_req_val_o  out  1  request valid to L1.5.
- l15_req_nc_o  out  1  1 = non-cacheable request.
- l15_req_size_o  out  3  3'b011 (8B) for nc, 3'b111 (line) for fill.
- l15_req_addr_o  out  PADDR_W  request address.
- l15_req_ack_i  in  1  L1.5 header accepted.
- l15_resp_val_i  in  1  response beat valid.
- l15_resp_type_i  in  4  returntype.
- l15_resp_data_i  in  64  response beat data.
- l15_resp_ack_o  out  1  beat consumed.

Behaviour:
- Reset: every output 0; FSM = IDLE; pending-nc flag, beat counter and line buffer cleared. Reset mid-transaction abandons it silently.
- nc capture: nc_req_valid_i sets nc_pend and registers the address in any state. A new pulse while nc_pend is already set overwrites the address; the latest request wins.
- fill_req_ready_o = (state==IDLE) & ~nc_pend & ~nc_req_valid_i. nc has strict priority, and the fill address is latched on the handshake.
- FSM states:
  - IDLE: nc_pend → REQ (nc). Otherwise fill handshake → REQ (fill).
  - REQ: l15_req_val_o=1 with stable nc/size/addr. Fill address is line-aligned (low log2(8*LINE_BEATS) bits zeroed); nc address has bits[2:0] zeroed. On l15_req_ack_i → WAIT. nc_pend clears on an nc ack, unless a new pulse arrives in that same cycle.
  - WAIT: l15_resp_ack_o = l15_resp_val_i. Any beat with type≠RTN_IFILL is acked and dropped, and the counter does not advance.
    - nc: the first IFILL beat drives nc_grant_valid_o=1 and nc_resp_data_o=l15_resp_data_i combinationally in the same cycle → IDLE.
    - fill: each IFILL beat is written to line slot [cnt], cnt++. On the beat with cnt==LINE_BEATS-1, fill_resp_valid_o is asserted the next cycle with the registered line, cnt wraps to 0 → IDLE.
- Latency: request to l15_req_val_o is 1 cycle. Last beat to fill_resp_valid_o is 1 cycle. nc grant is 0 cycles after its beat.
- Any l15_resp_val_i outside WAIT is acked and dropped.
- Back-to-back: on a same-cycle ack plus a fresh nc pulse, the FSM leaves IDLE the cycle after returning.

Decomposition:
- Shared package (sargantana_icache_pkg): the L1.5 request size constants, the RTN_IFILL code, the arbiter state enum {IDLE, REQ, WAIT}, and a struct for the L1.5 request bundle.
- Sub-module icache_l15_line_assembler holds the beat counter, line register and done pulse.

Test Plan:
1. nc_req_valid_i pulse, addr 40'h00_0001_0004 → l15_req_addr_o 40'h00_0001_0000, nc=1, size=3'b011. Ack, then beat 64'hDEAD_BEEF_0123_4567 → same-cycle nc_grant_valid_o with that data.
2. Fill request at addr 40'h80_0000_0028 → l15 addr 40'h80_0000_0020, size=3'b111. Four beats 1..4 → one cycle later fill_resp_line_o = {4,3,2,1}, pulse width 1.
3. nc pulse arrives while a fill is in WAIT → fill completes first, nc_pend held; nc request is issued the cycle after IDLE and fill_req_ready_o stays 0 meanwhile.
4. Fill in WAIT receives a beat with type 4'h3 between beats 1 and 2 → the beat is acked, the line excludes it, and fill_resp_valid_o fires only after 4 IFILL beats.
5. rst_i asserted after 2 of 4 beats → outputs 0 immediately. The next fill collects a clean 4 beats with no stale data.
6. l15_req_ack_i withheld for 5 cycles → l15_req_val_o and l15_req_addr_o remain stable throughout.
